// File: rtl/pll_lock_sequencer_pkg.sv
// pll_seq_pkg: shared types and constants for the PLL lock sequencer.
//   pll_state_e  - FSM state encoding, also exported on the debug state port
//   *_W          - widths of the status fields carried on the interface
//   LOSS_CNT_MAX - saturation value of the lock-loss counter
package pll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 2;
  localparam int LOSS_W  = 8;

  localparam logic [LOSS_W-1:0] LOSS_CNT_MAX = 8'hFF;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAIL       = 3'd4
  } pll_state_e;

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: PLL status/control bundle between the sequencer and
// its environment.
//   pll_locked  - raw PLL lock indication (asynchronous)
//   restart_req - level request for a full PLL re-lock
//   restart_ack - one-cycle acceptance pulse
//   pll_rst     - reset to the PLL
//   ready       - PLL locked and stable
//   fail        - retries exhausted
//   state       - sequencer state (debug)
//   retry_cnt   - timeouts in the current attempt sequence
//   loss_cnt    - saturating count of lock losses in RUN
// master: environment side; slave: sequencer side.
interface pll_lock_sequencer_if;

  logic                              pll_locked;
  logic                              restart_req;
  logic                              restart_ack;
  logic                              pll_rst;
  logic                              ready;
  logic                              fail;
  logic [pll_seq_pkg::STATE_W-1:0]   state;
  logic [pll_seq_pkg::RETRY_W-1:0]   retry_cnt;
  logic [pll_seq_pkg::LOSS_W-1:0]    loss_cnt;

  modport master (
    output pll_locked, restart_req,
    input  restart_ack, pll_rst, ready, fail, state, retry_cnt, loss_cnt
  );

  modport slave (
    input  pll_locked, restart_req,
    output restart_ack, pll_rst, ready, fail, state, retry_cnt, loss_cnt
  );

endinterface

// File: rtl/pll_lock_sequencer_sync.sv
// pll_lock_sync: two-flop synchronizer for a single asynchronous status bit,
// synchronous active-high reset to 0.
//   i_clk   - destination clock
//   i_rst   - synchronous reset
//   i_async - asynchronous input
//   o_sync  - synchronized output, 2-cycle latency
module pll_lock_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: holds the PLL in reset, waits for a debounced lock,
// retries on timeout, restarts on loss of lock and publishes a registered
// ready that gates downstream reset release. Runs on the reference clock.
//   refclk - reference clock, sole clock
//   rst    - synchronous active-high reset
//   bus    - status/control bundle (slave side), see pll_lock_sequencer_if
//
// state      | meaning
// RESET_HOLD | pll_rst asserted for RST_CYCLES
// WAIT_LOCK  | pll_rst released, waiting for synchronized lock or timeout
// STABLE     | counting consecutive locked cycles
// RUN        | locked and stable, ready asserted
// FAIL       | retries exhausted, PLL held in reset until restart or rst
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 20
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  pll_state_e          r_state, w_nxt_state;
  logic [CNT_W-1:0]    r_cnt, w_nxt_cnt;
  logic [RETRY_W-1:0]  r_retry, w_nxt_retry;
  logic [LOSS_W-1:0]   r_loss, w_nxt_loss;
  logic                r_pll_rst;
  logic                r_ready;
  logic                r_fail;
  logic                r_ack;
  logic                r_req_q;
  logic                w_locked_s;
  logic                w_restart;

  pll_lock_sync u_lock_sync (
    .i_clk   (refclk),
    .i_rst   (rst),
    .i_async (bus.pll_locked),
    .o_sync  (w_locked_s)
  );

  // Rising-edge qualified: a held request is accepted once only.
  assign w_restart = bus.restart_req & ~r_req_q;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_retry = r_retry;
    w_nxt_loss  = r_loss;
    if (w_restart) begin
      // Overrides every other transition, including a coincident lock loss.
      w_nxt_state = ST_RESET_HOLD;
      w_nxt_cnt   = '0;
      w_nxt_retry = '0;
    end else begin
      case (r_state)
        ST_RESET_HOLD: begin
          if (r_cnt == RST_LAST) begin
            w_nxt_state = ST_WAIT_LOCK;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_nxt_state = ST_STABLE;
            w_nxt_cnt   = '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_nxt_cnt = '0;
            if (r_retry == RETRY_LIMIT) begin
              w_nxt_state = ST_FAIL;
            end else begin
              w_nxt_retry = r_retry + RETRY_W'(1);
              w_nxt_state = ST_RESET_HOLD;
            end
          end else begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!w_locked_s) begin
            w_nxt_state = ST_WAIT_LOCK;
            w_nxt_cnt   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_nxt_state = ST_RUN;
            w_nxt_cnt   = '0;
            w_nxt_retry = '0;
          end else begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            w_nxt_state = ST_RESET_HOLD;
            w_nxt_cnt   = '0;
            if (r_loss != LOSS_CNT_MAX) begin
              w_nxt_loss = r_loss + LOSS_W'(1);
            end
          end
        end
        ST_FAIL: begin
          w_nxt_cnt = '0;
        end
        default: begin
          w_nxt_state = ST_RESET_HOLD;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state   <= ST_RESET_HOLD;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_loss    <= '0;
      r_pll_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
      r_ack     <= 1'b0;
      r_req_q   <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_retry   <= w_nxt_retry;
      r_loss    <= w_nxt_loss;
      // Flags are decoded from the next state so they change with it.
      r_pll_rst <= (w_nxt_state == ST_RESET_HOLD) || (w_nxt_state == ST_FAIL);
      r_ready   <= (w_nxt_state == ST_RUN);
      r_fail    <= (w_nxt_state == ST_FAIL);
      r_ack     <= w_restart;
      r_req_q   <= bus.restart_req;
    end
  end

  assign bus.restart_ack = r_ack;
  assign bus.pll_rst     = r_pll_rst;
  assign bus.ready       = r_ready;
  assign bus.fail        = r_fail;
  assign bus.state       = r_state;
  assign bus.retry_cnt   = r_retry;
  assign bus.loss_cnt    = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8, MAX_RETRY=2. A vector table walks normal lock, loss in
// RUN, the retry/fail path and restart handshakes; hand-written sequences
// cover the STABLE glitch, restart coinciding with loss, mid-operation
// reset and loss counter saturation.
module tb_pll_lock_sequencer;

  localparam int RH  = 0;
  localparam int WL  = 1;
  localparam int STB = 2;
  localparam int RUN = 3;
  localparam int FL  = 4;

  typedef struct {
    int         n;
    logic       locked;
    logic       req;
    logic [2:0] st;
    logic       pll_rst;
    logic       ready;
    logic       fail;
    logic       ack;
    logic [1:0] retry;
    logic [7:0] loss;
  } vec_t;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  pll_lock_sequencer_if bus_if ();

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (2),
    .CNT_W         (20)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus_if.slave)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(int n, int lk, int rq, int st, int pr, int rd,
                              int fl, int ak, int rt, int ls);
    vec_t v;
    v.n       = n;
    v.locked  = 1'(lk);
    v.req     = 1'(rq);
    v.st      = 3'(st);
    v.pll_rst = 1'(pr);
    v.ready   = 1'(rd);
    v.fail    = 1'(fl);
    v.ack     = 1'(ak);
    v.retry   = 2'(rt);
    v.loss    = 8'(ls);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int pr, input int rd,
                         input int fl, input int ak, input int rt, input int ls);
    chk({tag, ".state"},   32'(bus_if.state),       32'(st));
    chk({tag, ".pll_rst"}, 32'(bus_if.pll_rst),     32'(pr));
    chk({tag, ".ready"},   32'(bus_if.ready),       32'(rd));
    chk({tag, ".fail"},    32'(bus_if.fail),        32'(fl));
    chk({tag, ".ack"},     32'(bus_if.restart_ack), 32'(ak));
    chk({tag, ".retry"},   32'(bus_if.retry_cnt),   32'(rt));
    chk({tag, ".loss"},    32'(bus_if.loss_cnt),    32'(ls));
  endtask

  task automatic wait_state(input int s, input int max, input string name);
    int k = 0;
    while (32'(bus_if.state) != s && k < max) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (32'(bus_if.state) != s) begin
      n_fail++;
      $display("FAIL %s: timeout, state %0d expected %0d", name, bus_if.state, s);
    end
  endtask

  // One lock loss: wait for RUN, drop lock for one cycle, wait for RESET_HOLD.
  task automatic do_loss(input string name);
    wait_state(RUN, 60, {name, ".run"});
    bus_if.pll_locked = 1'b0;
    tick(1);
    bus_if.pll_locked = 1'b1;
    wait_state(RH, 10, {name, ".hold"});
  endtask

  initial begin
    bus_if.pll_locked  = 1'b0;
    bus_if.restart_req = 1'b0;

    //         n  lk rq st   pr rd fl ak rt ls
    vecs.push_back(mk( 3, 0, 0, RH,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 1, 0, 0, WL,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 2, 1, 0, WL,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 1, 1, 0, STB, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 7, 1, 0, STB, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 1, 1, 0, RUN, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk( 2, 0, 0, RUN, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk( 1, 0, 0, RH,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk( 3, 0, 0, RH,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk( 1, 0, 0, WL,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(31, 0, 0, WL,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk( 1, 0, 0, RH,  1, 0, 0, 0, 1, 1));
    vecs.push_back(mk( 4, 0, 0, WL,  0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(31, 0, 0, WL,  0, 0, 0, 0, 1, 1));
    vecs.push_back(mk( 1, 0, 0, RH,  1, 0, 0, 0, 2, 1));
    vecs.push_back(mk( 4, 0, 0, WL,  0, 0, 0, 0, 2, 1));
    vecs.push_back(mk(31, 0, 0, WL,  0, 0, 0, 0, 2, 1));
    vecs.push_back(mk( 1, 0, 0, FL,  1, 0, 1, 0, 2, 1));
    vecs.push_back(mk(20, 0, 0, FL,  1, 0, 1, 0, 2, 1));
    vecs.push_back(mk( 1, 0, 1, RH,  1, 0, 0, 1, 0, 1));
    vecs.push_back(mk( 1, 0, 1, RH,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk( 3, 0, 1, WL,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk( 1, 0, 0, WL,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk( 1, 0, 1, RH,  1, 0, 0, 1, 0, 1));
    vecs.push_back(mk( 1, 0, 0, RH,  1, 0, 0, 0, 0, 1));

    tick(3);
    chk_all("reset", RH, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      bus_if.pll_locked  = vecs[i].locked;
      bus_if.restart_req = vecs[i].req;
      tick(vecs[i].n);
      chk_all($sformatf("v%0d", i), int'(vecs[i].st), int'(vecs[i].pll_rst),
              int'(vecs[i].ready), int'(vecs[i].fail), int'(vecs[i].ack),
              int'(vecs[i].retry), int'(vecs[i].loss));
    end

    // One-cycle lock glitch while in STABLE.
    bus_if.pll_locked = 1'b1;
    wait_state(STB, 40, "glitch.enter");
    tick(3);
    bus_if.pll_locked = 1'b0;
    tick(1);
    bus_if.pll_locked = 1'b1;
    tick(1);
    chk("glitch.c2.state", 32'(bus_if.state), 32'(STB));
    tick(1);
    chk("glitch.c3.state", 32'(bus_if.state), 32'(WL));
    tick(8);
    chk("glitch.c11.state", 32'(bus_if.state), 32'(STB));
    chk("glitch.c11.ready", 32'(bus_if.ready), 32'd0);
    tick(1);
    chk("glitch.c12.state", 32'(bus_if.state), 32'(RUN));
    chk("glitch.c12.ready", 32'(bus_if.ready), 32'd1);

    // Restart accepted on the same edge the FSM sees the lock loss.
    bus_if.pll_locked = 1'b0;
    tick(2);
    chk("rst_loss.pre.state", 32'(bus_if.state), 32'(RUN));
    bus_if.restart_req = 1'b1;
    tick(1);
    chk_all("rst_loss", RH, 1, 0, 0, 1, 0, 1);
    bus_if.restart_req = 1'b0;
    bus_if.pll_locked  = 1'b1;
    tick(1);
    chk("rst_loss.ack_off", 32'(bus_if.restart_ack), 32'd0);

    // Four more losses to reach 5, then reset from STABLE.
    for (int i = 0; i < 4; i++) do_loss($sformatf("loss5_%0d", i));
    chk("loss5.count", 32'(bus_if.loss_cnt), 32'd5);
    wait_state(STB, 40, "midrst.enter");
    rst = 1'b1;
    tick(1);
    chk_all("midrst", RH, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Saturation of the loss counter.
    do_loss("sat_first");
    chk("sat.first", 32'(bus_if.loss_cnt), 32'd1);
    for (int i = 1; i < 255; i++) do_loss("sat_loop");
    chk("sat.255", 32'(bus_if.loss_cnt), 32'd255);
    do_loss("sat_extra");
    chk("sat.hold", 32'(bus_if.loss_cnt), 32'd255);
    chk("sat.ready", 32'(bus_if.ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
